// File: rtl/scan_bist_ctrl.sv
// Logic-BIST controller: a Galois PRPG drives DUT stimulus, and a MISR compacts
// the DUT responses into a signature that is compared against a golden value.
module scan_bist_ctrl #(
  parameter int              IN_W      = 36,
  parameter int              OUT_W     = 39,
  parameter int              NPAT      = 100,
  parameter int              CNT_W     = 16,
  parameter logic [IN_W-1:0] PRPG_POLY = 36'h800000400,
  parameter logic [IN_W-1:0] PRPG_SEED = 36'h000000001,
  parameter logic [OUT_W-1:0] MISR_POLY = 39'h4000000011
) (
  input  logic             CK,
  input  logic             RSTN,
  input  logic             start,
  input  logic [OUT_W-1:0] golden,
  input  logic [OUT_W-1:0] dut_resp,
  output logic [IN_W-1:0]  stim,
  output logic             stim_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [OUT_W-1:0] signature,
  output logic [CNT_W-1:0] pat_count
);

  if (PRPG_SEED == '0) begin : g_bad_seed
    $error("scan_bist_ctrl: PRPG_SEED must be nonzero");
  end
  if (NPAT < 1 || (64'(1) << CNT_W) <= 64'(NPAT)) begin : g_bad_npat
    $error("scan_bist_ctrl: NPAT must be >= 1 and fit in CNT_W bits");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [IN_W-1:0]  prpg_q, prpg_d;
  logic [IN_W-1:0]  stim_q, stim_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] sig_q, sig_d;
  logic             valid_q;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    prpg_d  = prpg_q;
    stim_d  = stim_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;

    // Responses lag stimulus by one cycle; valid_q is clear in IDLE/DONE,
    // so this never collides with the signature clear on start.
    if (valid_q) begin
      sig_d = (sig_q >> 1) ^ (sig_q[0] ? MISR_POLY : '0) ^ dut_resp;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          prpg_d  = PRPG_SEED;
          cnt_d   = '0;
          sig_d   = '0;
        end
      end
      S_RUN: begin
        stim_d = prpg_q;
        prpg_d = (prpg_q >> 1) ^ (prpg_q[0] ? PRPG_POLY : '0);
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NPAT - 1)) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CK) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
      prpg_q  <= PRPG_SEED;
      stim_q  <= PRPG_SEED;
      cnt_q   <= '0;
      sig_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prpg_q  <= prpg_d;
      stim_q  <= stim_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      valid_q <= stim_valid;
    end
  end

  // stim_q remembers the last issued pattern so stim holds once RUN ends.
  assign stim       = (state_q == S_RUN) ? prpg_q : stim_q;
  assign stim_valid = (state_q == S_RUN);
  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign pass       = done && (sig_q == golden);
  assign signature  = sig_q;
  assign pat_count  = cnt_q;

endmodule

// File: tb/tb_scan_bist_ctrl.sv
// Directed bench for scan_bist_ctrl: small 4-bit configurations with
// hand-computed PRPG/MISR sequences plus one default-parameter run.
module tb_scan_bist_ctrl;

  logic ck = 1'b0;
  logic rstn;
  always #5 ck = ~ck;

  int n_cmp = 0;
  int n_err = 0;

  // Instance A: 4-bit PRPG/MISR, NPAT = 5
  logic       start_a;
  logic [3:0] golden_a, resp_a, stim_a, sig_a, pat_a;
  logic       valid_a, busy_a, done_a, pass_a;

  // Instance B: 4-bit PRPG/MISR, NPAT = 2
  logic       start_b;
  logic [3:0] golden_b, resp_b, stim_b, sig_b, pat_b;
  logic       valid_b, busy_b, done_b, pass_b;

  // Instance C: default parameters
  logic        start_c;
  logic [38:0] golden_c, resp_c, sig_c;
  logic [35:0] stim_c;
  logic [15:0] pat_c;
  logic        valid_c, busy_c, done_c, pass_c;

  scan_bist_ctrl #(
    .IN_W(4), .OUT_W(4), .NPAT(5), .CNT_W(4),
    .PRPG_POLY(4'b1100), .PRPG_SEED(4'b0001), .MISR_POLY(4'b1100)
  ) u_a (
    .CK(ck), .RSTN(rstn), .start(start_a), .golden(golden_a), .dut_resp(resp_a),
    .stim(stim_a), .stim_valid(valid_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .signature(sig_a), .pat_count(pat_a)
  );

  scan_bist_ctrl #(
    .IN_W(4), .OUT_W(4), .NPAT(2), .CNT_W(4),
    .PRPG_POLY(4'b1100), .PRPG_SEED(4'b0001), .MISR_POLY(4'b1100)
  ) u_b (
    .CK(ck), .RSTN(rstn), .start(start_b), .golden(golden_b), .dut_resp(resp_b),
    .stim(stim_b), .stim_valid(valid_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .signature(sig_b), .pat_count(pat_b)
  );

  scan_bist_ctrl u_c (
    .CK(ck), .RSTN(rstn), .start(start_c), .golden(golden_c), .dut_resp(resp_c),
    .stim(stim_c), .stim_valid(valid_c), .busy(busy_c), .done(done_c),
    .pass(pass_c), .signature(sig_c), .pat_count(pat_c)
  );

  logic [3:0] exp_stim [5] = '{4'b0001, 4'b1100, 4'b0110, 4'b0011, 4'b1101};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_stim"},  stim_a,  4'b0001);
    check({tag, "_valid"}, valid_a, 1'b0);
    check({tag, "_busy"},  busy_a,  1'b0);
    check({tag, "_done"},  done_a,  1'b0);
    check({tag, "_pass"},  pass_a,  1'b0);
    check({tag, "_sig"},   sig_a,   4'b0000);
    check({tag, "_pat"},   pat_a,   4'd0);
  endtask

  // Called one step after the start edge; walks a full NPAT=5 run of A.
  // resp_a = 0001 gives signatures 0001, 1101, 1011, 1000, 0101.
  task automatic run_a_seq(input string tag);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("%s_stim%0d", tag, i),  stim_a,  exp_stim[i]);
      check($sformatf("%s_valid%0d", tag, i), valid_a, 1'b1);
      check($sformatf("%s_pat%0d", tag, i),   pat_a,   4'(i));
      step();
    end
    check({tag, "_drain_valid"}, valid_a, 1'b0);
    check({tag, "_drain_busy"},  busy_a,  1'b1);
    check({tag, "_drain_pat"},   pat_a,   4'd5);
    check({tag, "_drain_stim"},  stim_a,  4'b1101);
    step();
    check({tag, "_done"},  done_a,  1'b1);
    check({tag, "_valid"}, valid_a, 1'b0);
    check({tag, "_sig"},   sig_a,   4'b0101);
    check({tag, "_pass"},  pass_a,  1'b1);
    check({tag, "_pat"},   pat_a,   4'd5);
  endtask

  initial begin
    int cycles;
    int nvalid;

    rstn     = 1'b0;
    start_a  = 1'b0;
    start_b  = 1'b0;
    start_c  = 1'b0;
    golden_a = 4'b0101;
    resp_a   = 4'b0001;
    golden_b = 4'b1101;
    resp_b   = 4'b0001;
    golden_c = '0;
    resp_c   = '0;

    step();
    step();
    check_reset_a("rst");
    check("rst_b_busy", busy_b, 1'b0);
    check("rst_c_stim", stim_c, 36'h1);
    rstn = 1'b1;
    step();

    // PRPG sequence and stim_valid window
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    run_a_seq("prpg");

    // Two-pattern MISR run that matches golden
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    check("misr_r1_valid", valid_b, 1'b1);
    check("misr_r1_pat",   pat_b,   4'd0);
    step();
    check("misr_r2_valid", valid_b, 1'b1);
    check("misr_r2_pat",   pat_b,   4'd1);
    check("misr_r2_sig",   sig_b,   4'b0000);
    step();
    check("misr_drain_valid", valid_b, 1'b0);
    check("misr_drain_busy",  busy_b,  1'b1);
    check("misr_drain_done",  done_b,  1'b0);
    check("misr_drain_sig",   sig_b,   4'b0001);
    step();
    check("misr_done",      done_b, 1'b1);
    check("misr_done_sig",  sig_b,  4'b1101);
    check("misr_done_pass", pass_b, 1'b1);

    // Same run against a wrong golden
    golden_b = 4'b1100;
    start_b  = 1'b1;
    step();
    start_b = 1'b0;
    step();
    step();
    step();
    check("bad_gold_done", done_b, 1'b1);
    check("bad_gold_sig",  sig_b,  4'b1101);
    check("bad_gold_pass", pass_b, 1'b0);
    golden_b = 4'b1101;

    // Default configuration, all-zero responses
    start_c = 1'b1;
    step();
    start_c = 1'b0;
    cycles = 1;
    nvalid = 0;
    while (!done_c && cycles < 300) begin
      if (valid_c) nvalid++;
      step();
      cycles++;
    end
    check("def_latency", 64'(cycles), 64'd102);
    check("def_nvalid",  64'(nvalid), 64'd100);
    check("def_pat",     pat_c,       16'd100);
    check("def_sig",     sig_c,       39'h0);
    check("def_pass",    pass_c,      1'b1);

    // Reset on the third RUN cycle, with start asserted in the same cycle
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("abort_stim0", stim_a, 4'b0001);
    step();
    check("abort_stim1", stim_a, 4'b1100);
    step();
    check("abort_stim2", stim_a, 4'b0110);
    check("abort_busy",  busy_a, 1'b1);
    rstn    = 1'b0;
    start_a = 1'b1;
    step();
    check_reset_a("abort");
    check("abort_c_done", done_c, 1'b0);
    rstn = 1'b1;
    step();
    start_a = 1'b0;
    run_a_seq("rerun");

    // start held high across the whole run: restart only from DONE
    start_b = 1'b1;
    step();
    check("hold_r1_pat",  pat_b,  4'd0);
    check("hold_r1_busy", busy_b, 1'b1);
    step();
    check("hold_r2_pat",  pat_b,  4'd1);
    check("hold_r2_done", done_b, 1'b0);
    step();
    check("hold_drain_busy", busy_b, 1'b1);
    check("hold_drain_pat",  pat_b,  4'd2);
    step();
    check("hold_done1",     done_b, 1'b1);
    check("hold_done1_sig", sig_b,  4'b1101);
    step();
    check("hold_restart_busy", busy_b,  1'b1);
    check("hold_restart_done", done_b,  1'b0);
    check("hold_restart_sig",  sig_b,   4'b0000);
    check("hold_restart_pat",  pat_b,   4'd0);
    check("hold_restart_stim", stim_b,  4'b0001);
    step();
    step();
    step();
    start_b = 1'b0;
    check("hold_done2",      done_b, 1'b1);
    check("hold_done2_sig",  sig_b,  4'b1101);
    check("hold_done2_pass", pass_b, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/scan_bist_ctrl.md
SCAN_BIST_CTRL -- requirements
Module: scan_bist_ctrl

Interface
REQ-001 The module SHALL have parameter IN_W, default 36, giving the stimulus width (DUT primary inputs).
REQ-002 The module SHALL have parameter OUT_W, default 39, giving the response width (DUT primary outputs).
REQ-003 The module SHALL have parameter NPAT, default 100, giving the number of patterns per run; NPAT >= 1.
REQ-004 The module SHALL have parameter CNT_W, default 16, giving the pattern counter width; 2^CNT_W > NPAT.
REQ-005 The module SHALL have parameter PRPG_POLY (IN_W bits), giving the Galois feedback mask.
REQ-006 The module SHALL have parameter PRPG_SEED (IN_W bits, nonzero), giving the initial PRPG state.
REQ-007 The module SHALL have parameter MISR_POLY (OUT_W bits), giving the MISR feedback mask.
REQ-008 The module SHALL have port CK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-009 The module SHALL have port RSTN, input, 1 bit: reset, synchronous and active-low.
REQ-010 The module SHALL have port start, input, 1 bit: run request.
REQ-011 The module SHALL have port golden, input, OUT_W bits: expected final signature.
REQ-012 The module SHALL have port dut_resp, input, OUT_W bits: DUT outputs.
REQ-013 The module SHALL have port stim, output, IN_W bits: pattern driven to DUT inputs.
REQ-014 The module SHALL have port stim_valid, output, 1 bit: stim is a counted pattern.
REQ-015 The module SHALL have ports busy and done, output, 1 bit each: status.
REQ-016 The module SHALL have port pass, output, 1 bit: signature == golden, valid while done.
REQ-017 The module SHALL have ports signature (output, OUT_W bits: MISR state) and pat_count (output, CNT_W bits: patterns issued).

Function
REQ-018 The FSM SHALL have states IDLE, RUN, DRAIN, DONE; busy = 1 in RUN or DRAIN; done = 1 only in DONE.
REQ-019 In IDLE or DONE, start = 1 SHALL move the FSM to RUN next cycle, load PRPG := PRPG_SEED, and clear signature and pat_count.
REQ-020 start SHALL be ignored in RUN and DRAIN.
REQ-021 In RUN, stim_valid SHALL be 1, stim SHALL equal the PRPG state, and each cycle: PRPG := (PRPG >> 1) XOR (PRPG[0] ? PRPG_POLY : 0), and pat_count += 1.
REQ-022 The first RUN cycle SHALL present stim = PRPG_SEED.
REQ-023 The RUN cycle with pat_count = NPAT-1 SHALL be the last; the FSM SHALL go to DRAIN with pat_count = NPAT.
REQ-024 The DUT response SHALL be sampled with one cycle latency via registered valid_d = stim_valid.
REQ-025 When valid_d = 1: signature := ((signature >> 1) XOR (signature[0] ? MISR_POLY : 0)) XOR dut_resp, giving exactly NPAT updates per run.
REQ-026 DRAIN SHALL last one cycle (the final MISR update) and then go to DONE.
REQ-027 In DONE, signature and pat_count SHALL hold, and pass = (signature == golden) combinationally.
REQ-028 Outside RUN, stim SHALL hold its last value, stim_valid = 0, and PRPG and pat_count SHALL not advance.
REQ-029 A start sampled in DONE SHALL restart the run identically (same seed, signature cleared) with no idle cycle.
REQ-030 A PRPG_SEED of 0 SHALL be an elaboration-time error.

Reset
REQ-031 RSTN = 0 at a rising CK edge SHALL force: IDLE, PRPG = PRPG_SEED, stim = PRPG_SEED, stim_valid = 0, valid_d = 0, busy = 0, done = 0, pass = 0, signature = 0, pat_count = 0.
REQ-032 Reset during RUN or DRAIN SHALL abort the run with no partial done or pass.
REQ-033 RSTN SHALL take priority over start in the same cycle.

Verification
REQ-034 The bench SHALL cover: IN_W=4, PRPG_POLY=4'b1100, seed 4'b0001, NPAT=5, start pulse -> stim 0001, 1100, 0110, 0011, 1101 with stim_valid high exactly 5 cycles; pat_count = 5.
REQ-035 The bench SHALL cover: OUT_W=4, MISR_POLY=4'b1100, NPAT=2, dut_resp held 4'b0001, golden 4'b1101 -> signature 0001 then 1101; done high 2 cycles after the last stim_valid; pass = 1.
REQ-036 The bench SHALL cover: the same run with golden 4'b1100 -> done = 1, pass = 0.
REQ-037 The bench SHALL cover: defaults (36/39/100), dut_resp = 0, golden = 0 -> 100 patterns, signature = 0, pass = 1, start-to-done = 102 cycles.
REQ-038 The bench SHALL cover: RSTN low on the third RUN cycle -> all outputs at their reset values next edge; a new start then reproduces the full sequence from the seed.
REQ-039 The bench SHALL cover: start held high through RUN and DRAIN -> no restart mid-run; restart on the first DONE cycle; second signature equals the first.
